// File: rtl/dcache_wb_buffer_pkg.sv
// Shared constants and types for the data-cache write-back buffer.
//   WB_DEPTH : number of buffered lines
//   LINE_AW  : line-address width (byte address without the 3 offset bits)
//   WB_AW    : byte-address width
//   DW       : line width in bits
//   wb_state_e : drain FSM encoding (IDLE=0, REQ=1)
package dcache_wb_buffer_pkg;

  localparam int WB_DEPTH = 4;
  localparam int LINE_AW  = 12;
  localparam int WB_AW    = 15;
  localparam int DW       = 64;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/dcache_wb_buffer_if.sv
// Bundle of the write-back buffer's cache-side, memory-side and lookup
// signals.
//   slave  : the buffer (takes evicts/acks/lookups, drives status/memory/hit)
//   master : the cache + memory environment around it
interface dcache_wb_buffer_if #(
  parameter int AW = dcache_wb_buffer_pkg::WB_AW,
  parameter int DW = dcache_wb_buffer_pkg::DW
);

  logic          evict;
  logic [AW-1:0] evict_addr;
  logic [DW-1:0] evict_data;
  logic          wb_full;
  logic          wb_empty;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic [AW-1:0] lkp_addr;
  logic          lkp_hit;
  logic [DW-1:0] lkp_data;
  logic          ovf_err;

  modport slave (
    input  evict, evict_addr, evict_data, mem_ack, lkp_addr,
    output wb_full, wb_empty, mem_req, mem_addr, mem_data,
           lkp_hit, lkp_data, ovf_err
  );

  modport master (
    output evict, evict_addr, evict_data, mem_ack, lkp_addr,
    input  wb_full, wb_empty, mem_req, mem_addr, mem_data,
           lkp_hit, lkp_data, ovf_err
  );

endinterface

// File: rtl/dcache_wb_buffer_entry.sv
// One write-back buffer slot: valid flag, line address and line data.
//   wr_en_i    : allocate the slot (valid=1, address and data written)
//   coal_en_i  : overwrite the data only (coalescing evict)
//   clr_i      : release the slot (allocation wins if both are set)
//   match_o    : slot is valid and holds lkp_addr_i
//   wr_match_o : slot is valid and holds wr_addr_i
module wb_entry #(
  parameter int LAW = dcache_wb_buffer_pkg::LINE_AW,
  parameter int DW  = dcache_wb_buffer_pkg::DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en_i,
  input  logic           coal_en_i,
  input  logic           clr_i,
  input  logic [LAW-1:0] wr_addr_i,
  input  logic [DW-1:0]  wr_data_i,
  input  logic [LAW-1:0] lkp_addr_i,
  output logic [LAW-1:0] addr_o,
  output logic [DW-1:0]  data_o,
  output logic           match_o,
  output logic           wr_match_o
);

  logic           valid_q;
  logic [LAW-1:0] addr_q;
  logic [DW-1:0]  data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           valid_q <= 1'b0;
    else if (wr_en_i)   valid_q <= 1'b1;
    else if (clr_i)     valid_q <= 1'b0;
  end

  // NOTE: address/data storage is deliberately not reset; it is only ever
  // observed through valid_q, so resetting it would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en_i)              addr_q <= wr_addr_i;
    if (wr_en_i || coal_en_i) data_q <= wr_data_i;
  end

  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign match_o    = valid_q && (addr_q == lkp_addr_i);
  assign wr_match_o = valid_q && (addr_q == wr_addr_i);

endmodule

// File: rtl/dcache_wb_buffer.sv
// Data-cache write-back buffer: a DEPTH-line circular FIFO of evicted dirty
// lines, drained to memory over a req/ack handshake, with coalescing of
// repeated evicts and youngest-match forwarding to a miss lookup.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : evict input, wb_full/wb_empty status, mem req/addr/data/ack,
//              lkp_addr -> lkp_hit/lkp_data, sticky ovf_err
module dcache_wb_buffer import dcache_wb_buffer_pkg::*; #(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = dcache_wb_buffer_pkg::DW
) (
  input logic               clk,
  input logic               rst,
  dcache_wb_buffer_if.slave bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int LAW = AW - 3;

  typedef logic [PW-1:0] ptr_t;

  wb_state_e      state_q, state_d;
  ptr_t           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_data_q, mem_data_d;
  logic           wb_full_q, wb_empty_q, ovf_q, ovf_d;
  logic           mem_req;

  logic [LAW-1:0] ev_line, lkp_line;
  logic [DEPTH-1:0] e_wr_en, e_coal_en, e_clr, e_match, e_wr_match;
  logic [LAW-1:0] e_addr [DEPTH];
  logic [DW-1:0]  e_data [DEPTH];

  logic           pop, push, coal;
  ptr_t           coal_idx, lkp_idx;
  logic           lkp_hit;
  logic [DW-1:0]  lkp_data;
  logic           unused_offset;

  assign ev_line       = bus.evict_addr[AW-1:3];
  assign lkp_line      = bus.lkp_addr[AW-1:3];
  assign unused_offset = ^{bus.evict_addr[2:0], bus.lkp_addr[2:0]};

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    wb_entry #(.LAW(LAW), .DW(DW)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (e_wr_en[g]),
      .coal_en_i  (e_coal_en[g]),
      .clr_i      (e_clr[g]),
      .wr_addr_i  (ev_line),
      .wr_data_i  (bus.evict_data),
      .lkp_addr_i (lkp_line),
      .addr_o     (e_addr[g]),
      .data_o     (e_data[g]),
      .match_o    (e_match[g]),
      .wr_match_o (e_wr_match[g])
    );
  end

  // Evict acceptance: coalesce into a matching slot unless it is the head
  // currently presented to memory, else push, else flag overflow.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    pop      = (state_q == REQ) && bus.mem_ack;
    coal     = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.evict && e_wr_match[i] && !((state_q == REQ) && (ptr_t'(i) == head_q))) begin
        coal     = 1'b1;
        coal_idx = ptr_t'(i);
      end
    end
    push  = bus.evict && !coal && ((count_q < CW'(DEPTH)) || pop);
    ovf_d = ovf_q || (bus.evict && !coal && !push);

    e_wr_en   = '0;
    e_coal_en = '0;
    e_clr     = '0;
    if (push) e_wr_en[tail_q]     = 1'b1;
    if (coal) e_coal_en[coal_idx] = 1'b1;
    if (pop)  e_clr[head_q]       = 1'b1;

    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Drain FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Drain FSM: next state. A push into an empty buffer starts the request
  // in the very next cycle rather than waiting for the count to register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((count_q != '0) || push) state_d = REQ;
      REQ:     if (bus.mem_ack)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drain FSM: outputs. The head line is captured on entry to REQ so it
  // stays stable for the whole request; a same-cycle coalesce into the head
  // (only possible while IDLE) is bypassed into the captured data.
  always_comb begin
    mem_req    = (state_q == REQ);
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if ((state_q == IDLE) && (state_d == REQ)) begin
      if (count_q == '0) begin
        mem_addr_d = {ev_line, 3'b000};
        mem_data_d = bus.evict_data;
      end else begin
        mem_addr_d = {e_addr[head_q], 3'b000};
        mem_data_d = (coal && (coal_idx == head_q)) ? bus.evict_data : e_data[head_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      wb_full_q  <= 1'b0;
      wb_empty_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wb_full_q  <= (count_d == CW'(DEPTH));
      wb_empty_q <= (count_d == '0);
      ovf_q      <= ovf_d;
    end
  end

  // Youngest-match forwarding: walk from head (oldest) towards tail so the
  // last hit seen is the one closest to the tail.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_data = '0;
    lkp_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lkp_idx = head_q + ptr_t'(k);
      if (e_match[lkp_idx]) begin
        lkp_hit  = 1'b1;
        lkp_data = e_data[lkp_idx];
      end
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.wb_full  = wb_full_q;
  assign bus.wb_empty = wb_empty_q;
  assign bus.ovf_err  = ovf_q;
  assign bus.lkp_hit  = lkp_hit;
  assign bus.lkp_data = lkp_data;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer. A transaction-level queue holds
// the lines the buffer should contain, in drain order; evicts push/coalesce
// into it as they are driven and memory handshakes pop it.
module tb_dcache_wb_buffer;

  typedef struct {
    logic [14:0] addr;
    logic [63:0] data;
  } line_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wb_buffer_if #(.AW(15), .DW(64)) bus ();

  dcache_wb_buffer #(.DEPTH(4), .AW(15), .DW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  line_t sb[$];
  bit    m_req;
  bit    m_ovf;
  int    n_cmp;
  int    n_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at a falling edge: check outputs against the model, drive one
  // cycle of stimulus, advance the model and move to the next falling edge.
  task automatic step(input bit ev, input logic [14:0] a, input logic [63:0] d, input bit ack);
    int  hit;
    int  first;
    bit  pop;
    check("mem_req", bus.mem_req, m_req);
    check("wb_full", bus.wb_full, sb.size() == 4);
    check("wb_empty", bus.wb_empty, sb.size() == 0);
    check("ovf_err", bus.ovf_err, m_ovf);
    if (m_req && sb.size() > 0) begin
      check("mem_addr", bus.mem_addr, sb[0].addr);
      check("mem_data", bus.mem_data, sb[0].data);
    end
    bus.evict      = ev;
    bus.evict_addr = a;
    bus.evict_data = d;
    bus.mem_ack    = ack;

    pop   = ack && m_req;
    hit   = -1;
    first = m_req ? 1 : 0;
    for (int i = first; i < sb.size(); i++)
      if (sb[i].addr[14:3] == a[14:3]) hit = i;
    if (ev) begin
      if (hit >= 0)                   sb[hit].data = d;
      else if (sb.size() < 4 || pop)  sb.push_back('{{a[14:3], 3'b000}, d});
      else                            m_ovf = 1'b1;
    end
    if (pop) void'(sb.pop_front());
    m_req = m_req ? !ack : (sb.size() != 0);

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lookup(input logic [14:0] a);
    logic        hit;
    logic [63:0] d;
    hit = 1'b0;
    d   = '0;
    bus.lkp_addr = a;
    #1;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].addr[14:3] == a[14:3]) begin
        hit = 1'b1;
        d   = sb[i].data;
      end
    check("lkp_hit", bus.lkp_hit, hit);
    check("lkp_data", bus.lkp_data, d);
  endtask

  task automatic drain();
    repeat (12) step(1'b0, '0, '0, 1'b1);
  endtask

  task automatic do_reset();
    bus.evict = 1'b0;
    bus.mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    sb.delete();
    m_req = 1'b0;
    m_ovf = 1'b0;
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, '0);
    check("rst_mem_data", bus.mem_data, '0);
    check("rst_wb_full", bus.wb_full, 1'b0);
    check("rst_wb_empty", bus.wb_empty, 1'b1);
    check("rst_ovf_err", bus.ovf_err, 1'b0);
    check("rst_lkp_hit", bus.lkp_hit, 1'b0);
    check("rst_lkp_data", bus.lkp_data, '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.evict      = 1'b0;
    bus.evict_addr = '0;
    bus.evict_data = '0;
    bus.mem_ack    = 1'b0;
    bus.lkp_addr   = '0;
    rst            = 1'b0;
    n_cmp          = 0;
    n_err          = 0;
    @(negedge clk);
    do_reset();

    // Single evict, memory holds ack low for three cycles, then acks.
    step(1'b1, 15'h1238, 64'hDEADBEEF_00000001, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);       // ack while idle must be ignored
    step(1'b0, '0, '0, 1'b0);

    // Fill to four lines, fifth on an ack cycle, sixth overflows.
    do_reset();
    for (int i = 1; i <= 4; i++)
      step(1'b1, 15'(8 * i), 64'h1000 + 64'(i), 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 15'h0028, 64'h1005, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 15'h0030, 64'h1006, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    drain();

    // Coalesce into a non-head entry.
    do_reset();
    step(1'b1, 15'h0040, 64'hAAAA, 1'b0);
    step(1'b1, 15'h0048, 64'hBBBB, 1'b0);
    step(1'b1, 15'h0048, 64'hCCCC, 1'b0);
    lookup(15'h0048);
    step(1'b0, '0, '0, 1'b0);
    drain();

    // The presented head is never coalesced; the youngest copy forwards.
    step(1'b1, 15'h0040, 64'hA1A1, 1'b0);
    step(1'b1, 15'h0040, 64'hB2B2, 1'b0);
    lookup(15'h0043);
    drain();

    // Forwarding, and no forwarding of a same-cycle evict.
    step(1'b1, 15'h0100, 64'h1111_2222_3333_4444, 1'b0);
    step(1'b1, 15'h0200, 64'h5555_6666_7777_8888, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    lookup(15'h0204);
    lookup(15'h0300);
    lookup(15'h0100);
    bus.evict      = 1'b1;
    bus.evict_addr = 15'h0700;
    bus.evict_data = 64'h7777;
    lookup(15'h0700);
    step(1'b1, 15'h0700, 64'h7777, 1'b0);
    lookup(15'h0700);
    drain();

    // Push and pop together with a single line buffered.
    step(1'b1, 15'h0500, 64'h5050, 1'b0);
    step(1'b1, 15'h0600, 64'h6060, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    drain();

    // Mixed random traffic over a small address set.
    for (int c = 0; c < 80; c++) begin
      lookup(15'(8 * $urandom_range(1, 7)));
      step(1'($urandom_range(0, 1)), 15'(8 * $urandom_range(1, 7)),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset in the middle of a request discards everything at once.
    do_reset();
    step(1'b1, 15'h0080, 64'h80, 1'b0);
    step(1'b1, 15'h0088, 64'h88, 1'b0);
    step(1'b1, 15'h0090, 64'h90, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_mem_req", bus.mem_req, 1'b0);
    check("async_rst_wb_empty", bus.wb_empty, 1'b1);
    sb.delete();
    m_req = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    lookup(15'h0080);
    lookup(15'h0088);
    lookup(15'h0090);
    step(1'b0, '0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_wb_buffer.md
# dcache_wb_buffer

Write-back buffer directly downstream of the data-cache store array. It captures dirty lines evicted on a memory fill (`evict`, `evict_addr`, `evict_data`) into a 4-entry FIFO and drains them to the memory interface with a req/ack handshake. It exposes `wb_full` so the fill path stalls instead of overflowing. It also forwards pending line data to a miss lookup, so a refetch of a just-evicted line never reads stale memory.

## Interface
- `DEPTH`, 4, number of buffered lines (power of two, ≥2)
- `AW`, 15, byte address width
- `DW`, 64, line width in bits
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `evict` in 1: evicted line valid this cycle
- `evict_addr` in AW: evicted line address; bits [2:0] ignored
- `evict_data` in DW: evicted line data
- `wb_full` out 1: no free entry and no coalesce possible; the cache must not assert `evict`
- `wb_empty` out 1: buffer holds no lines
- `mem_req` out 1: write request to memory
- `mem_addr` out AW: head line address, [2:0]=0
- `mem_data` out DW: head line data
- `mem_ack` in 1: memory accepted the request
- `lkp_addr` in AW: miss address to check
- `lkp_hit` out 1: a pending line matches `lkp_addr[14:3]` (combinational)
- `lkp_data` out DW: data of the youngest matching entry
- `ovf_err` out 1: sticky; set if an evict arrived while it could not be accepted

## Operation
- Storage is a circular FIFO with head pointer, tail pointer and count. Each entry holds valid, line address [14:3] and DW data.
- Pointer arithmetic wraps modulo DEPTH. Count width is log2(DEPTH)+1.
- Accepting `evict`:
  - **Coalesce:** if a valid entry matches the line address and is not the head while in REQ, overwrite that entry's data. Count is unchanged.
  - **Push:** otherwise push at the tail if count<DEPTH, or if count==DEPTH and an ack pops in the same cycle.
  - **Overflow:** otherwise drop the line and set `ovf_err`. State is unchanged.
- Drain FSM:
  - IDLE: go to REQ when count≠0.
  - REQ: `mem_req`=1 with head addr/data. On `mem_ack`, pop the head (clear valid, head+1, count−1) and go to IDLE.
- `mem_addr` and `mem_data` are stable for the whole REQ. The head entry is never coalesced while presented.
- Lookup compares `lkp_addr[14:3]` against all valid entries. It returns the youngest match, i.e. closest to the tail.
- Lookup sees registered state only; a same-cycle `evict` is not forwarded.
- `wb_full` = (count==DEPTH). `wb_empty` = (count==0).
- `mem_ack` outside REQ is ignored.

## Timing
- All outputs are registered except `lkp_hit` and `lkp_data`.
- Reset values:
  - FSM in IDLE; pointers and count 0; all valids 0.
  - `mem_req`=0, `mem_addr`=0, `mem_data`=0.
  - `wb_full`=0, `wb_empty`=1, `ovf_err`=0, `lkp_hit`=0, `lkp_data`=0.
- Evict in cycle N: the entry is visible to lookup in N+1, and `mem_req` rises in N+1 if the FSM was IDLE with count 0.
- Ack in cycle M: `mem_req`=0 in M+1. It re-asserts in M+2 if count≠0. Minimum 2 cycles per line.
- Simultaneous push and pop at count==DEPTH: both take effect, count stays DEPTH, no error.
- Simultaneous push and pop at count==1: the new line becomes the head and `mem_req` re-asserts 2 cycles later.
- Reset asserted mid-REQ: `mem_req` drops immediately (asynchronously) and all buffered lines are discarded.

## Structure
- Constants `WB_DEPTH`, `LINE_AW=12`, `DW`, and the FSM state encoding (IDLE=0, REQ=1) go in the shared dcache package.
- Sub-module `wb_entry`: one valid/addr/data register with write-enable, coalesce-enable, clear, and a comparator producing `match`.
- The top level instantiates DEPTH copies of `wb_entry` plus the pointers, count, FSM and youngest-match priority select.

## Test plan
- **Single evict, delayed ack:** evict addr 0x1238, data 0xDEADBEEF_00000001; hold `mem_ack`=0 for 3 cycles, then 1 -> `mem_req` high from N+1, `mem_addr`=0x1238, data stable; `wb_empty`=1 after the ack.
- **Fill:** 4 evicts to lines 0x08, 0x10, 0x18, 0x20 with `mem_ack`=0 -> `wb_full`=1. A 5th evict with no ack -> `ovf_err`=1, count stays 4. A 5th evict on an ack cycle -> accepted, no error.
- **Coalesce:** evict 0x40 data A, then 0x48 B, then 0x48 C while 0x40 is in REQ -> count=2. Drain order is 0x40:A, then 0x48:C.
- **Head protection:** evict 0x40 data A, then 0x40 data B while the head is in REQ -> a second entry is pushed; memory sees A, then B.
- **Forwarding:** buffer 0x100:X and 0x200:Y; `lkp_addr`=0x204 -> `lkp_hit`=1, `lkp_data`=Y. `lkp_addr`=0x300 -> `lkp_hit`=0.
- **Reset during REQ:** with 3 entries pending, pulse `rst` low -> `mem_req`=0 at once. After release: `wb_empty`=1, and lookup of any buffered address misses.
